// File: rtl/cover_toggle_collector_if.sv
// Output stream of newly covered point indices: valid/ready handshake plus index payload.
// The collector drives the master side; the consumer holds the slave side.
interface cover_toggle_collector_if #(
    parameter int IDX_W = 32
);
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_index;

    modport master (output out_valid, output out_index, input out_ready);
    modport slave  (input out_valid, input out_index, output out_ready);
endinterface

// File: rtl/cover_toggle_collector.sv
// Toggle-coverage collector: sticky first-hit bitmap per point, streaming each newly
// covered point's global index exactly once, lowest index first.
module cover_toggle_collector #(
    parameter int WIDTH       = 8,
    parameter int COVER_INDEX = 0,
    parameter int COVER_TOTAL = 8940,
    parameter int IDX_W       = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           valid_i,
    input  logic                       clear_i,
    cover_toggle_collector_if.master   out_if,
    output logic [$clog2(WIDTH+1)-1:0] hit_count_o,
    output logic                       all_covered_o
);
    localparam int HC_W = $clog2(WIDTH+1);

    generate
        if (COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_bad_params
            $error("cover_toggle_collector: COVER_INDEX+WIDTH exceeds COVER_TOTAL");
        end
    endgenerate

    typedef enum logic {IDLE, PRESENT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] seen_q, seen_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [HC_W-1:0]  hit_count_q, hit_count_d;
    logic             all_covered_q, all_covered_d;
    logic             out_valid_q, out_valid_d;
    logic [IDX_W-1:0] out_index_q, out_index_d;

    logic [WIDTH-1:0] new_hits;
    logic [WIDTH-1:0] sel_mask;
    int               sel_idx;
    logic             load;

    // Clear wins over same-cycle hits, so nothing captured while clearing.
    assign new_hits = clear_i ? '0 : (valid_i & ~seen_q);

    always_comb begin
        sel_idx  = 0;
        sel_mask = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel_idx  = i;
                sel_mask = '0;
                sel_mask[i] = 1'b1;
            end
        end
    end

    always_comb begin
        hit_count_d = clear_i ? '0 : hit_count_q;
        for (int i = 0; i < WIDTH; i++) begin
            hit_count_d = hit_count_d + HC_W'(new_hits[i]);
        end
        all_covered_d = (hit_count_d == HC_W'(WIDTH));
        seen_d        = clear_i ? '0 : (seen_q | new_hits);
    end

    // Loads are suppressed while clearing so a clear mid-drain stops further beats.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_index_d = out_index_q;
        load        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if ((pending_q != '0) && !clear_i) begin
                    load    = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (out_if.out_ready) begin
                    if ((pending_q != '0) && !clear_i) begin
                        load = 1'b1;
                    end else begin
                        out_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            out_valid_d = 1'b1;
            out_index_d = IDX_W'(COVER_INDEX + sel_idx);
        end
        pending_d = (clear_i ? '0 : (pending_q & ~(load ? sel_mask : '0))) | new_hits;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            seen_q        <= '0;
            pending_q     <= '0;
            hit_count_q   <= '0;
            all_covered_q <= 1'b0;
            out_valid_q   <= 1'b0;
            out_index_q   <= '0;
        end else begin
            state_q       <= state_d;
            seen_q        <= seen_d;
            pending_q     <= pending_d;
            hit_count_q   <= hit_count_d;
            all_covered_q <= all_covered_d;
            out_valid_q   <= out_valid_d;
            out_index_q   <= out_index_d;
        end
    end

    assign out_if.out_valid = out_valid_q;
    assign out_if.out_index = out_index_q;
    assign hit_count_o      = hit_count_q;
    assign all_covered_o    = all_covered_q;
endmodule

// File: tb/tb_cover_toggle_collector.sv
// Randomised and directed bench for cover_toggle_collector against a set-based reference
// model (seen set, pending set, currently presented point).
module tb_cover_toggle_collector;
    localparam int W     = 8;
    localparam int CI    = 100;
    localparam int IDX_W = 32;
    localparam int HC_W  = $clog2(W+1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [W-1:0]     valid_i = '0;
    logic             clear_i = 1'b0;
    logic [HC_W-1:0]  hit_count_o;
    logic             all_covered_o;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    bit [W-1:0] m_seen;
    bit [W-1:0] m_pend;
    int         m_cur;
    int         acc_q[$];

    cover_toggle_collector_if #(.IDX_W(IDX_W)) bus ();

    cover_toggle_collector #(
        .WIDTH(W), .COVER_INDEX(CI), .COVER_TOTAL(8940), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .clear_i(clear_i),
        .out_if(bus.master), .hit_count_o(hit_count_o), .all_covered_o(all_covered_o)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_seen = '0;
        m_pend = '0;
        m_cur  = -1;
    endtask

    task automatic model_edge(input bit [W-1:0] v, input bit clr, input bit rdy);
        bit hs;
        int nxt;
        hs  = (m_cur >= 0) && rdy;
        nxt = -1;
        if (m_cur < 0 || hs) begin
            if (!clr) for (int i = W - 1; i >= 0; i--) if (m_pend[i]) nxt = i;
            if (nxt >= 0) m_pend[nxt] = 1'b0;
            if (nxt >= 0 || hs) m_cur = nxt;
        end
        if (clr) begin
            m_seen = '0;
            m_pend = '0;
        end else begin
            m_pend = m_pend | (v & ~m_seen);
            m_seen = m_seen | v;
        end
    endtask

    // Drive one cycle of inputs, log any DUT-side accepted beat, advance the model.
    task automatic cycle(input bit [W-1:0] v, input bit clr, input bit rdy);
        valid_i       = v;
        clear_i       = clr;
        bus.out_ready = rdy;
        @(posedge clk);
        if (bus.out_valid && rdy) acc_q.push_back(int'(bus.out_index));
        model_edge(v, clr, rdy);
        #1;
    endtask

    task automatic settle();
        cycle('0, 1'b1, 1'b1);
        cycle('0, 1'b1, 1'b1);
        acc_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.out_ready = 1'b0;
        model_reset();
        #12;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.out_index !== '0 || hit_count_o !== '0 || all_covered_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: valid=%0b index=%0d count=%0d all=%0b, required all zero",
                     bus.out_valid, bus.out_index, hit_count_o, all_covered_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #4;
    endtask

    task automatic test_two_hits();
        settle();
        cycle(8'b0000_0101, 1'b0, 1'b1);
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_t1: out_valid=%0b, required 0", bus.out_valid);
        end
        for (int k = 0; k < 5; k++) cycle('0, 1'b0, 1'b1);
        vectors++;
        if (acc_q.size() != 2 || acc_q[0] != 100 || acc_q[1] != 102) begin
            miscompares++;
            $display("FAIL two_hits_order: got %p, required '{100,102}", acc_q);
        end
        vectors++;
        if (hit_count_o !== 4'd2 || bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL two_hits_count: count=%0d valid=%0b, required 2 and 0", hit_count_o, bus.out_valid);
        end
    endtask

    task automatic test_repeat_hit();
        settle();
        for (int k = 0; k < 10; k++) cycle(8'b0000_0001, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) cycle('0, 1'b0, 1'b1);
        vectors++;
        if (acc_q.size() != 1 || acc_q[0] != 100) begin
            miscompares++;
            $display("FAIL repeat_hit: got %p, required '{100}", acc_q);
        end
    endtask

    task automatic test_stall();
        settle();
        cycle(8'b0010_0000, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) cycle('0, 1'b0, 1'b0);
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_index !== 32'd105) begin
            miscompares++;
            $display("FAIL stall_present: valid=%0b index=%0d, required 1 and 105", bus.out_valid, bus.out_index);
        end
        cycle(8'b0000_0010, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) cycle('0, 1'b0, 1'b0);
        vectors++;
        if (bus.out_index !== 32'd105) begin
            miscompares++;
            $display("FAIL stall_no_preempt: index=%0d, required 105", bus.out_index);
        end
        for (int k = 0; k < 4; k++) cycle('0, 1'b0, 1'b1);
        vectors++;
        if (acc_q.size() != 2 || acc_q[0] != 105 || acc_q[1] != 101) begin
            miscompares++;
            $display("FAIL stall_order: got %p, required '{105,101}", acc_q);
        end
    endtask

    task automatic test_back_to_back();
        int first_beat;
        bit consecutive;
        settle();
        cycle(8'hFF, 1'b0, 1'b1);
        cycle('0, 1'b0, 1'b1);
        consecutive = 1'b1;
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_index !== IDX_W'(CI + k)) begin
                miscompares++;
                consecutive = 1'b0;
                $display("FAIL b2b_beat%0d: valid=%0b index=%0d, required 1 and %0d",
                         k, bus.out_valid, bus.out_index, CI + k);
            end
            cycle('0, 1'b0, 1'b1);
        end
        first_beat = acc_q.size();
        vectors++;
        if (!consecutive || first_beat != 8 || bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_drain: beats=%0d valid=%0b, required 8 and 0", first_beat, bus.out_valid);
        end
        vectors++;
        if (hit_count_o !== 4'd8 || all_covered_o !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_full: count=%0d all=%0b, required 8 and 1", hit_count_o, all_covered_o);
        end
    endtask

    task automatic test_clear_drain();
        settle();
        cycle(8'h0F, 1'b0, 1'b0);
        cycle('0, 1'b0, 1'b0);
        cycle(8'h10, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) cycle('0, 1'b0, 1'b1);
        vectors++;
        if (acc_q.size() != 1 || acc_q[0] != 100 || hit_count_o !== '0 || all_covered_o !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_drain: got %p count=%0d, required '{100} and 0", acc_q, hit_count_o);
        end
        cycle(8'h10, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) cycle('0, 1'b0, 1'b1);
        vectors++;
        if (acc_q.size() != 2 || acc_q[1] != 104 || hit_count_o !== 4'd1) begin
            miscompares++;
            $display("FAIL clear_rehit: got %p count=%0d, required '{100,104} and 1", acc_q, hit_count_o);
        end
    endtask

    task automatic test_random();
        bit [W-1:0] v;
        bit clr, rdy;
        int exp_cnt;
        settle();
        for (int n = 0; n < 400; n++) begin
            v   = ($urandom_range(0, 5) == 0) ? W'($urandom) : '0;
            clr = ($urandom_range(0, 59) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            cycle(v, clr, rdy);
            exp_cnt = $countones(m_seen);
            vectors++;
            if (bus.out_valid !== (m_cur >= 0) ||
                (m_cur >= 0 && bus.out_index !== IDX_W'(CI + m_cur)) ||
                hit_count_o !== HC_W'(exp_cnt) || all_covered_o !== (exp_cnt == W)) begin
                miscompares++;
                $display("FAIL random_cyc%0d: valid=%0b index=%0d count=%0d all=%0b, required valid=%0b index=%0d count=%0d all=%0b",
                         n, bus.out_valid, bus.out_index, hit_count_o, all_covered_o,
                         (m_cur >= 0), CI + m_cur, exp_cnt, (exp_cnt == W));
            end
        end
    endtask

    task automatic test_async_reset();
        settle();
        cycle(8'b1110_0110, 1'b0, 1'b0);
        cycle('0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.out_index !== '0 || hit_count_o !== '0 || all_covered_o !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: valid=%0b index=%0d count=%0d all=%0b, required all zero",
                     bus.out_valid, bus.out_index, hit_count_o, all_covered_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #4;
        acc_q.delete();
        for (int k = 0; k < 6; k++) cycle('0, 1'b0, 1'b1);
        vectors++;
        if (acc_q.size() != 0 || bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_idle: beats=%0d valid=%0b, required 0 and 0", acc_q.size(), bus.out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_two_hits();
        test_repeat_hit();
        test_stall();
        test_back_to_back();
        test_clear_drain();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
